// File: rtl/mem_pkg.sv
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared types for the L1-to-memory arbiter: cache/memory request
//             and response structs, block size, arbiter state encoding,
//             performance-counter bundle and a saturating-increment helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int BLOCKSIZE = 128;
  localparam int ADDR_W    = 32;

  typedef struct packed {
    logic              Valid;
    logic              Wen;
    logic [ADDR_W-1:0] Addr;
    logic [BLOCKSIZE-1:0] WriteD;
  } CacheToMem_t;

  typedef struct packed {
    logic                 Ready;
    logic [BLOCKSIZE-1:0] ReadD;
  } MemToCache_t;

  typedef struct packed {
    logic [31:0] InsGrants;
    logic [31:0] DatGrants;
    logic [31:0] ContendCycles;
  } ArbStats_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_INS = 2'd1,
    GRANT_DAT = 2'd2,
    RELEASE   = 2'd3
  } arb_state_e;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] i_val);
    return (i_val == 32'hFFFF_FFFF) ? i_val : i_val + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Bundles the instruction-cache, data-cache and main-memory
//             request/response structs seen by the arbiter.
//  Ports    : InsReq_i/InsResp_o  - L1 instruction cache side
//             DatReq_i/DatResp_o  - L1 data cache side
//             MemReq_o/MemResp_i  - main memory side
//  Modports : slave  - arbiter view
//             master - environment view (caches + memory)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if;
  import mem_pkg::*;

  CacheToMem_t InsReq_i;
  MemToCache_t InsResp_o;
  CacheToMem_t DatReq_i;
  MemToCache_t DatResp_o;
  CacheToMem_t MemReq_o;
  MemToCache_t MemResp_i;

  modport slave (
    input  InsReq_i, DatReq_i, MemResp_i,
    output InsResp_o, DatResp_o, MemReq_o
  );

  modport master (
    output InsReq_i, DatReq_i, MemResp_i,
    input  InsResp_o, DatResp_o, MemReq_o
  );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-input round-robin arbiter. Bit 0 = instruction cache,
//             bit 1 = data cache. On a tie the requester that did not win
//             last time is granted. The last-grant bit resets to DAT so the
//             instruction cache wins the first tie.
//  Ports    : clk_i, rst_i - clock, synchronous active-high reset
//             i_req[1:0]   - request vector
//             i_accept     - grant is being taken this cycle
//             o_gnt[1:0]   - one-hot (or zero) grant
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);

  logic r_last_dat;

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = r_last_dat ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_dat <= 1'b1;
    end else if (i_accept && (o_gnt != 2'b00)) begin
      r_last_dat <= o_gnt[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Arbitrates the L1 instruction and data caches onto one main
//             memory port. The winner's request is captured into a holding
//             register which alone drives the memory request; the memory
//             response is passed straight through to the granted cache.
//             Instruction-side requests are always issued as reads.
//  Ports    : clk_i   - clock, rising edge
//             rst_i   - synchronous active-high reset
//             bus     - mem_arbiter_if.slave (cache and memory structs)
//             Stats_o - performance counters (only with MEM_ARB_STATS_EN)
//  Config   : `define MEM_ARB_STATS_EN to add three 32-bit saturating
//             counters (InsGrants, DatGrants, ContendCycles) on Stats_o.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  mem_arbiter_if.slave    bus
`ifdef MEM_ARB_STATS_EN
  ,
  output ArbStats_t       Stats_o
`endif
);

  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  logic [1:0]            w_req;
  logic [1:0]            w_gnt;
  logic                  w_accept;
  logic                  w_in_grant;

  logic                  r_wen;
  logic [ADDR_W-1:0]     r_addr;
  logic [BLOCKSIZE-1:0]  r_wdata;

  logic                  w_win_wen;
  logic [ADDR_W-1:0]     w_win_addr;
  logic [BLOCKSIZE-1:0]  w_win_wdata;

  MemToCache_t           w_ins_resp;
  MemToCache_t           w_dat_resp;
  CacheToMem_t           w_mem_req;

  assign w_req = {bus.DatReq_i.Valid, bus.InsReq_i.Valid};

  rr_arb2 u_rr_arb2 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_gnt    (w_gnt)
  );

  // Next-state logic; the arbiter is only consulted in IDLE, so requester
  // Valid changes while a grant is outstanding have no effect.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt[0]) begin
          w_state_nxt = GRANT_INS;
          w_accept    = 1'b1;
        end else if (w_gnt[1]) begin
          w_state_nxt = GRANT_DAT;
          w_accept    = 1'b1;
        end
      end
      GRANT_INS, GRANT_DAT: begin
        if (bus.MemResp_i.Ready) begin
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Winner's fields; the instruction path is read-only.
  always_comb begin
    w_win_wen   = bus.DatReq_i.Wen;
    w_win_addr  = bus.DatReq_i.Addr;
    w_win_wdata = bus.DatReq_i.WriteD;
    if (w_gnt[0]) begin
      w_win_wen   = 1'b0;
      w_win_addr  = bus.InsReq_i.Addr;
      w_win_wdata = bus.InsReq_i.WriteD;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_wen   <= w_win_wen;
        r_addr  <= w_win_addr;
        r_wdata <= w_win_wdata;
      end
    end
  end

  assign w_in_grant = (r_state == GRANT_INS) || (r_state == GRANT_DAT);

  always_comb begin
    w_mem_req        = '0;
    w_mem_req.Valid  = w_in_grant;
    w_mem_req.Wen    = r_wen;
    w_mem_req.Addr   = r_addr;
    w_mem_req.WriteD = r_wdata;
  end

  // Ready is gated by state, so memory Ready in IDLE/RELEASE never leaks.
  always_comb begin
    w_ins_resp.Ready = (r_state == GRANT_INS) && bus.MemResp_i.Ready;
    w_ins_resp.ReadD = bus.MemResp_i.ReadD;
    w_dat_resp.Ready = (r_state == GRANT_DAT) && bus.MemResp_i.Ready;
    w_dat_resp.ReadD = bus.MemResp_i.ReadD;
  end

  assign bus.MemReq_o  = w_mem_req;
  assign bus.InsResp_o = w_ins_resp;
  assign bus.DatResp_o = w_dat_resp;

`ifdef MEM_ARB_STATS_EN
  ArbStats_t r_stats;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stats <= '0;
    end else begin
      if (w_accept && w_gnt[0]) begin
        r_stats.InsGrants <= sat_inc(r_stats.InsGrants);
      end
      if (w_accept && w_gnt[1]) begin
        r_stats.DatGrants <= sat_inc(r_stats.DatGrants);
      end
      if ((r_state != IDLE) && (w_req == 2'b11)) begin
        r_stats.ContendCycles <= sat_inc(r_stats.ContendCycles);
      end
    end
  end

  assign Stats_o = r_stats;
`else
  // Counters not built; arbitration is unaffected.
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter: directed scenarios plus a
//             randomized run against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
  import mem_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  mem_arbiter_if u_if ();

`ifdef MEM_ARB_STATS_EN
  ArbStats_t w_stats;
`endif

  mem_arbiter u_dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bus     (u_if)
`ifdef MEM_ARB_STATS_EN
    ,
    .Stats_o (w_stats)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus for the next cycle
  logic                 d_rst;
  logic                 d_iv, d_iw, d_dv, d_dw, d_mr;
  logic [ADDR_W-1:0]    d_ia, d_da;
  logic [BLOCKSIZE-1:0] d_id, d_dd, d_mrd;

  // Reference model: one outstanding transaction, a one-cycle cool-down
  // after completion, and a "who won last" flag for ties.
  bit                   m_known;
  bit                   m_busy, m_cool, m_who_dat, m_last_dat;
  logic                 m_wen;
  logic [ADDR_W-1:0]    m_addr;
  logic [BLOCKSIZE-1:0] m_wd;
  logic [31:0]          m_ins_g, m_dat_g, m_cont;

  // Observations
  int                   n_ins_rdy, n_dat_rdy;
  logic [ADDR_W-1:0]    q_addr[$];
  logic                 q_wen[$];
  logic [BLOCKSIZE-1:0] q_wd[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BLOCKSIZE-1:0] rnd_blk();
    logic [BLOCKSIZE-1:0] v;
    for (int i = 0; i < BLOCKSIZE / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic quiet();
    d_rst = 0; d_iv = 0; d_iw = 0; d_dv = 0; d_dw = 0; d_mr = 0;
    d_ia = '0; d_da = '0; d_id = '0; d_dd = '0; d_mrd = '0;
  endtask

  task automatic tick();
    bit e_ir, e_dr, both, win_dat;
    @(negedge clk_i);
    rst_i         = d_rst;
    u_if.InsReq_i = '{Valid: d_iv, Wen: d_iw, Addr: d_ia, WriteD: d_id};
    u_if.DatReq_i = '{Valid: d_dv, Wen: d_dw, Addr: d_da, WriteD: d_dd};
    u_if.MemResp_i = '{Ready: d_mr, ReadD: d_mrd};
    #1;
    if (m_known) begin
      e_ir = m_busy && !m_who_dat && d_mr;
      e_dr = m_busy &&  m_who_dat && d_mr;
      check("mem_valid", u_if.MemReq_o.Valid, m_busy);
      check("mem_addr",  u_if.MemReq_o.Addr,  m_addr);
      check("mem_wen",   u_if.MemReq_o.Wen,   m_wen);
      check("mem_wdata", u_if.MemReq_o.WriteD, m_wd);
      check("ins_ready", u_if.InsResp_o.Ready, e_ir);
      check("dat_ready", u_if.DatResp_o.Ready, e_dr);
      if (e_ir) check("ins_readd", u_if.InsResp_o.ReadD, d_mrd);
      if (e_dr) check("dat_readd", u_if.DatResp_o.ReadD, d_mrd);
`ifdef MEM_ARB_STATS_EN
      check("st_ins",  w_stats.InsGrants, m_ins_g);
      check("st_dat",  w_stats.DatGrants, m_dat_g);
      check("st_cont", w_stats.ContendCycles, m_cont);
`endif
    end
    if (u_if.InsResp_o.Ready === 1'b1) n_ins_rdy++;
    if (u_if.DatResp_o.Ready === 1'b1) n_dat_rdy++;
    if (u_if.MemReq_o.Valid === 1'b1 && d_mr) begin
      q_addr.push_back(u_if.MemReq_o.Addr);
      q_wen.push_back(u_if.MemReq_o.Wen);
      q_wd.push_back(u_if.MemReq_o.WriteD);
    end
    @(posedge clk_i);
    // Advance the reference model on this edge.
    if (d_rst) begin
      m_known = 1; m_busy = 0; m_cool = 0; m_last_dat = 1; m_who_dat = 0;
      m_wen = 0; m_addr = '0; m_wd = '0;
      m_ins_g = 0; m_dat_g = 0; m_cont = 0;
    end else begin
      both = d_iv && d_dv;
      if ((m_busy || m_cool) && both && m_cont != 32'hFFFF_FFFF) m_cont++;
      if (m_busy) begin
        if (d_mr) begin m_busy = 0; m_cool = 1; end
      end else if (m_cool) begin
        m_cool = 0;
      end else if (d_iv || d_dv) begin
        win_dat    = both ? !m_last_dat : d_dv;
        m_last_dat = win_dat;
        m_who_dat  = win_dat;
        m_busy     = 1;
        if (win_dat) begin
          m_addr = d_da; m_wen = d_dw; m_wd = d_dd;
          if (m_dat_g != 32'hFFFF_FFFF) m_dat_g++;
        end else begin
          m_addr = d_ia; m_wen = 1'b0; m_wd = d_id;
          if (m_ins_g != 32'hFFFF_FFFF) m_ins_g++;
        end
      end
    end
  endtask

  task automatic do_reset();
    quiet();
    d_rst = 1; tick(); tick();
    d_rst = 0;
    n_ins_rdy = 0; n_dat_rdy = 0;
    q_addr.delete(); q_wen.delete(); q_wd.delete();
  endtask

  initial begin
    logic [BLOCKSIZE-1:0] x_data;
    m_known = 0;
    quiet();

    // Data-only read, memory answers on the third grant cycle.
    do_reset();
    tick();  // reset-state outputs checked here by the model
    d_dv = 1; d_da = 32'h100; d_dw = 0;
    tick();
    tick(); tick();
    d_mr = 1; d_mrd = {(BLOCKSIZE/8){8'hA5}};
    tick();
    quiet(); tick(); tick();
    check("r27_dat_pulses", n_dat_rdy, 1);
    check("r27_ins_pulses", n_ins_rdy, 0);
    check("r27_addr", (q_addr.size() > 0) ? q_addr[0] : 32'hDEAD, 32'h100);

    // Sustained contention from the first cycle after reset.
    do_reset();
    d_iv = 1; d_ia = 32'h200; d_dv = 1; d_da = 32'h300; d_mr = 1;
    d_mrd = rnd_blk();
    for (int i = 0; i < 8; i++) tick();
    quiet(); tick();
    check("r28_count", q_addr.size(), 3);
    if (q_addr.size() == 3) begin
      check("r28_g0", q_addr[0], 32'h200);
      check("r28_g1", q_addr[1], 32'h300);
      check("r28_g2", q_addr[2], 32'h200);
    end

    // Instruction write request is issued as a read.
    do_reset();
    d_iv = 1; d_iw = 1; d_ia = 32'h40; d_id = rnd_blk();
    tick();
    d_iv = 0; d_mr = 1;
    tick();
    quiet(); tick();
    check("r29_count", q_addr.size(), 1);
    if (q_wen.size() == 1) begin
      check("r29_wen", q_wen[0], 1'b0);
      check("r29_addr", q_addr[0], 32'h40);
    end

    // Data write whose Valid drops mid-grant still completes.
    do_reset();
    x_data = rnd_blk();
    d_dv = 1; d_dw = 1; d_da = 32'h80; d_dd = x_data;
    tick();
    d_dv = 0; d_dd = '0;
    tick();
    d_mr = 1;
    tick();
    quiet(); tick();
    check("r30_dat_pulses", n_dat_rdy, 1);
    if (q_wd.size() == 1) begin
      check("r30_wdata", q_wd[0], x_data);
      check("r30_wen", q_wen[0], 1'b1);
    end else begin
      check("r30_count", q_wd.size(), 1);
    end

    // Reset during GRANT_DAT abandons the transaction.
    do_reset();
    d_dv = 1; d_da = 32'h300;
    tick();
    tick();
    d_rst = 1; tick();
    d_rst = 0; d_dv = 0; d_mr = 1; d_mrd = rnd_blk();
    tick();
    d_mr = 0; tick();
    check("r31_ins_pulses", n_ins_rdy, 0);
    check("r31_dat_pulses", n_dat_rdy, 0);
    #1;
    check("r31_mem_valid", u_if.MemReq_o.Valid, 1'b0);

`ifdef MEM_ARB_STATS_EN
    // Four contended transactions, both Valids held throughout.
    do_reset();
    d_iv = 1; d_ia = 32'h10; d_dv = 1; d_da = 32'h20; d_mr = 1;
    for (int i = 0; i < 12; i++) tick();
    quiet(); tick();
    #1;
    check("r32_ins_grants", w_stats.InsGrants, 2);
    check("r32_dat_grants", w_stats.DatGrants, 2);
    check("r32_contend", w_stats.ContendCycles, 8);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      d_rst = ($urandom_range(0, 63) == 0);
      d_iv  = ($urandom_range(0, 9) < 6);
      d_dv  = ($urandom_range(0, 9) < 6);
      d_iw  = $urandom_range(0, 1);
      d_dw  = $urandom_range(0, 1);
      d_ia  = $urandom;
      d_da  = $urandom;
      d_id  = rnd_blk();
      d_dd  = rnd_blk();
      d_mr  = ($urandom_range(0, 9) < 4);
      d_mrd = rnd_blk();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
